// File: rtl/mem_walker_nested_iter_pkg.sv
// Shared types for the nested-loop strided address walker.
// Group state encodings and the loop/group count helper.
package mem_walker_nested_iter_pkg;

  typedef enum logic [1:0] {
    GS_IDLE   = 2'd0,
    GS_ACTIVE = 2'd1,
    GS_DONE   = 2'd2
  } grp_state_e;

  function automatic int num_max(input int id_w);
    return 1 << id_w;
  endfunction

endpackage

// File: rtl/mem_walker_nested_iter_group_ctx.sv
// One walk context: config regs, loop counters, level addresses,
// odometer advance and IDLE/ACTIVE/DONE state.
module mem_walker_nested_iter_group_ctx
  import mem_walker_nested_iter_pkg::*;
#(
  parameter int AW = 48,
  parameter int SW = 16,
  parameter int IW = 16,
  parameter int LW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic          adv_i,
  input  logic          stride_we_i,
  input  logic          iter_we_i,
  input  logic          base_we_i,
  input  logic [LW-1:0] loop_id_i,
  input  logic [SW-1:0] stride_i,
  input  logic [IW-1:0] iter_i,
  input  logic [AW-1:0] base_i,
  output logic [AW-1:0] addr_o,
  output logic          active_o,
  output logic          last_o,
  output logic          done_o
);

  localparam int NL = num_max(LW);

  grp_state_e    state_q, state_d;
  logic          done_q, done_d;
  logic [AW-1:0] base_q;
  logic [SW-1:0] stride_q [NL];
  logic [IW-1:0] iter_q [NL];
  logic [IW-1:0] cnt_q [NL];
  logic [IW-1:0] cnt_d [NL];
  logic [IW-1:0] cnt_step [NL];
  logic [AW-1:0] addr_q [NL];
  logic [AW-1:0] addr_d [NL];
  logic [NL-1:0] wrap;
  logic [LW-1:0] h;
  logic          carry;
  logic [AW-1:0] step_addr;

  // an iteration count of 0 behaves as 1
  always_comb begin
    for (int l = 0; l < NL; l++) begin
      if (iter_q[l] == '0) wrap[l] = (cnt_q[l] == '0);
      else wrap[l] = (cnt_q[l] == iter_q[l] - IW'(1));
    end
  end

  assign last_o   = &wrap;
  assign active_o = (state_q == GS_ACTIVE);
  assign done_o   = done_q;
  assign addr_o   = addr_q[0];

  always_comb begin
    carry = 1'b1;
    h     = '0;
    for (int l = 0; l < NL; l++) begin
      cnt_step[l] = cnt_q[l];
      if (carry) begin
        if (wrap[l]) begin
          cnt_step[l] = '0;
        end else begin
          cnt_step[l] = cnt_q[l] + IW'(1);
          h = l[LW-1:0];
        end
        carry = wrap[l];
      end
    end
    step_addr = addr_q[h]
              + {{(AW-SW){stride_q[h][SW-1]}}, stride_q[h]};
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    if (start_i) begin
      state_d = GS_ACTIVE;
      for (int l = 0; l < NL; l++) begin
        cnt_d[l]  = '0;
        addr_d[l] = base_q;
      end
    end else if (adv_i && state_q == GS_ACTIVE) begin
      if (last_o) begin
        state_d = GS_DONE;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_step;
        for (int l = 0; l < NL; l++) begin
          if (l <= int'(h)) addr_d[l] = step_addr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= GS_IDLE;
      done_q  <= 1'b0;
      base_q  <= '0;
      for (int l = 0; l < NL; l++) begin
        stride_q[l] <= '0;
        iter_q[l]   <= '0;
        cnt_q[l]    <= '0;
        addr_q[l]   <= '0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      if (stride_we_i) stride_q[loop_id_i] <= stride_i;
      if (iter_we_i) iter_q[loop_id_i] <= iter_i;
      if (base_we_i) base_q <= base_i;
    end
  end

endmodule

// File: rtl/mem_walker_nested_iter.sv
// Strided nested-loop address walker with per-group resumable contexts.
// Holds cfg decode, output mux and cfg_err/done/busy aggregation.
module mem_walker_nested_iter
  import mem_walker_nested_iter_pkg::*;
#(
  parameter int ADDR_WIDTH    = 48,
  parameter int ADDR_STRIDE_W = 16,
  parameter int ITER_W        = 16,
  parameter int LOOP_ID_W     = 3,
  parameter int GROUP_ID_W    = 2,
  parameter int GROUP_ENABLED = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [GROUP_ID_W-1:0]        cfg_group_id,
  input  logic [LOOP_ID_W-1:0]         cfg_loop_id,
  input  logic                         cfg_stride_v,
  input  logic [ADDR_STRIDE_W-1:0]     cfg_stride,
  input  logic                         cfg_iter_v,
  input  logic [ITER_W-1:0]            cfg_iter,
  input  logic                         cfg_base_v,
  input  logic [ADDR_WIDTH-1:0]        cfg_base,
  output logic                         cfg_err,
  input  logic                         start,
  input  logic [GROUP_ID_W-1:0]        start_group_id,
  input  logic [GROUP_ID_W-1:0]        loop_group_id,
  output logic [ADDR_WIDTH-1:0]        addr_out,
  output logic                         addr_out_valid,
  input  logic                         addr_out_ready,
  output logic                         addr_out_last,
  output logic [(1<<GROUP_ID_W)-1:0]   group_done,
  output logic [(1<<GROUP_ID_W)-1:0]   group_busy
);

  localparam int NG = num_max(GROUP_ID_W);
  localparam int NI = (GROUP_ENABLED != 0) ? NG : 1;

  logic [GROUP_ID_W-1:0] cfg_gid, start_gid, sel_gid;
  logic                  any_wr;
  logic [NG-1:0]         st_hit, drop, busy, last_v, done_v;
  logic [ADDR_WIDTH-1:0] addr_v [NG];
  logic                  cfg_err_q;

  assign cfg_gid   = (GROUP_ENABLED != 0) ? cfg_group_id : '0;
  assign start_gid = (GROUP_ENABLED != 0) ? start_group_id : '0;
  assign sel_gid   = (GROUP_ENABLED != 0) ? loop_group_id : '0;
  assign any_wr    = cfg_stride_v | cfg_iter_v | cfg_base_v;

  for (genvar g = 0; g < NG; g++) begin : g_grp
    logic hit;
    assign hit       = (cfg_gid == GROUP_ID_W'(g));
    assign st_hit[g] = start && (start_gid == GROUP_ID_W'(g));
    // a start in the same cycle also blocks the write
    assign drop[g]   = hit && any_wr && (busy[g] || st_hit[g]);
    if (g < NI) begin : g_ctx
      logic ok, adv;
      assign ok  = hit && !drop[g];
      assign adv = (sel_gid == GROUP_ID_W'(g))
                && addr_out_ready && !st_hit[g];
      mem_walker_nested_iter_group_ctx #(
        .AW (ADDR_WIDTH),
        .SW (ADDR_STRIDE_W),
        .IW (ITER_W),
        .LW (LOOP_ID_W)
      ) u_ctx (
        .clk         (clk),
        .reset       (reset),
        .start_i     (st_hit[g]),
        .adv_i       (adv),
        .stride_we_i (ok && cfg_stride_v),
        .iter_we_i   (ok && cfg_iter_v),
        .base_we_i   (ok && cfg_base_v),
        .loop_id_i   (cfg_loop_id),
        .stride_i    (cfg_stride),
        .iter_i      (cfg_iter),
        .base_i      (cfg_base),
        .addr_o      (addr_v[g]),
        .active_o    (busy[g]),
        .last_o      (last_v[g]),
        .done_o      (done_v[g])
      );
    end else begin : g_off
      assign busy[g]   = 1'b0;
      assign last_v[g] = 1'b0;
      assign done_v[g] = 1'b0;
      assign addr_v[g] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cfg_err_q <= 1'b0;
    else cfg_err_q <= |drop;
  end

  assign cfg_err        = cfg_err_q;
  assign addr_out       = addr_v[sel_gid];
  assign addr_out_valid = busy[sel_gid];
  assign addr_out_last  = busy[sel_gid] & last_v[sel_gid];
  assign group_done     = done_v;
  assign group_busy     = busy;

endmodule

// File: tb/tb_mem_walker_nested_iter.sv
// Scoreboard bench for mem_walker_nested_iter.
// Expected beats come from a closed-form base + sum(cnt*stride) model.
module tb_mem_walker_nested_iter;

  localparam int AW = 48;
  localparam int SW = 16;
  localparam int IW = 16;
  localparam int LW = 3;
  localparam int GW = 2;
  localparam int NG = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [GW-1:0] cfg_group_id = '0;
  logic [LW-1:0] cfg_loop_id = '0;
  logic          cfg_stride_v = 1'b0;
  logic [SW-1:0] cfg_stride = '0;
  logic          cfg_iter_v = 1'b0;
  logic [IW-1:0] cfg_iter = '0;
  logic          cfg_base_v = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic          cfg_err;
  logic          start = 1'b0;
  logic [GW-1:0] start_group_id = '0;
  logic [GW-1:0] loop_group_id = '0;
  logic [AW-1:0] addr_out;
  logic          addr_out_valid;
  logic          addr_out_ready = 1'b0;
  logic          addr_out_last;
  logic [NG-1:0] group_done;
  logic [NG-1:0] group_busy;

  typedef logic [AW+2:0] exp_t;
  exp_t sbq[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  mem_walker_nested_iter dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_group_id   (cfg_group_id),
    .cfg_loop_id    (cfg_loop_id),
    .cfg_stride_v   (cfg_stride_v),
    .cfg_stride     (cfg_stride),
    .cfg_iter_v     (cfg_iter_v),
    .cfg_iter       (cfg_iter),
    .cfg_base_v     (cfg_base_v),
    .cfg_base       (cfg_base),
    .cfg_err        (cfg_err),
    .start          (start),
    .start_group_id (start_group_id),
    .loop_group_id  (loop_group_id),
    .addr_out       (addr_out),
    .addr_out_valid (addr_out_valid),
    .addr_out_ready (addr_out_ready),
    .addr_out_last  (addr_out_last),
    .group_done     (group_done),
    .group_busy     (group_busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    cfg_stride_v = 1'b0;
    cfg_iter_v = 1'b0;
    cfg_base_v = 1'b0;
    addr_out_ready = 1'b0;
    cyc();
    reset = 1'b0;
    sbq.delete();
  endtask

  task automatic wr_stride(input int g, input int l, input logic [SW-1:0] s);
    cfg_group_id = g[GW-1:0];
    cfg_loop_id = l[LW-1:0];
    cfg_stride = s;
    cfg_stride_v = 1'b1;
    cyc();
    cfg_stride_v = 1'b0;
  endtask

  task automatic wr_iter(input int g, input int l, input logic [IW-1:0] n);
    cfg_group_id = g[GW-1:0];
    cfg_loop_id = l[LW-1:0];
    cfg_iter = n;
    cfg_iter_v = 1'b1;
    cyc();
    cfg_iter_v = 1'b0;
  endtask

  task automatic wr_base(input int g, input logic [AW-1:0] b);
    cfg_group_id = g[GW-1:0];
    cfg_base = b;
    cfg_base_v = 1'b1;
    cyc();
    cfg_base_v = 1'b0;
  endtask

  task automatic go(input int g);
    start_group_id = g[GW-1:0];
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  function automatic logic [AW-1:0] sx(input logic [SW-1:0] s);
    return {{(AW-SW){s[SW-1]}}, s};
  endfunction

  task automatic push_walk(input int g, input logic [AW-1:0] base,
                           input int it0, input int it1,
                           input logic [SW-1:0] s0,
                           input logic [SW-1:0] s1);
    int n0, n1;
    logic [AW-1:0] a;
    logic lst;
    n0 = (it0 == 0) ? 1 : it0;
    n1 = (it1 == 0) ? 1 : it1;
    for (int i1 = 0; i1 < n1; i1++) begin
      for (int i0 = 0; i0 < n0; i0++) begin
        a = base + AW'(i1) * sx(s1) + AW'(i0) * sx(s0);
        lst = (i0 == n0 - 1) && (i1 == n1 - 1);
        sbq.push_back({g[1:0], lst, a});
      end
    end
  endtask

  function automatic int find_g(input int g);
    for (int i = 0; i < sbq.size(); i++) begin
      if (int'(sbq[i][AW+2:AW+1]) == g) return i;
    end
    return -1;
  endfunction

  task automatic drop_g(input int g);
    int idx;
    idx = find_g(g);
    while (idx >= 0) begin
      sbq.delete(idx);
      idx = find_g(g);
    end
  endtask

  // consume up to nbeats beats of group g (-1: all); stall one beat
  task automatic drain(input int g, input int nbeats,
                       input int stall_at, input int stall_n);
    int beat, stalled, n, idx;
    exp_t e;
    beat = 0;
    stalled = 0;
    n = 0;
    loop_group_id = g[GW-1:0];
    #1;
    while (n < 400) begin
      idx = find_g(g);
      if (idx < 0 || (nbeats >= 0 && beat >= nbeats)) break;
      e = sbq[idx];
      addr_out_ready = !(beat == stall_at && stalled < stall_n);
      tests_run++;
      if (addr_out_valid !== 1'b1 || addr_out !== e[AW-1:0]
          || addr_out_last !== e[AW]) begin
        tests_failed++;
        $display("FAIL beat g%0d #%0d: valid=%b addr=%h last=%b, want 1 %h %b",
                 g, beat, addr_out_valid, addr_out, addr_out_last,
                 e[AW-1:0], e[AW]);
      end
      if (addr_out_ready) begin
        sbq.delete(idx);
        beat++;
      end else begin
        stalled++;
      end
      cyc();
      n++;
    end
    addr_out_ready = 1'b0;
    tests_run++;
    if (n >= 400) begin
      tests_failed++;
      $display("FAIL drain_timeout g%0d: beats=%0d", g, beat);
    end
  endtask

  task automatic chk_done(input int g, input logic [NG-1:0] busy_exp);
    logic [NG-1:0] d;
    d = '0;
    d[g] = 1'b1;
    tests_run++;
    if (group_done !== d || group_busy !== busy_exp) begin
      tests_failed++;
      $display("FAIL done_pulse g%0d: done=%b busy=%b, want %b %b",
               g, group_done, group_busy, d, busy_exp);
    end
    cyc();
    tests_run++;
    if (group_done !== '0) begin
      tests_failed++;
      $display("FAIL done_once g%0d: done=%b, want 0", g, group_done);
    end
  endtask

  task automatic cfg_t1(input int g);
    wr_iter(g, 0, 16'd3);
    wr_iter(g, 1, 16'd2);
    wr_stride(g, 0, 16'd4);
    wr_stride(g, 1, 16'h100);
    wr_base(g, 48'h1000);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    cfg_stride_v = 1'b1;
    addr_out_ready = 1'b1;
    cyc();
    tests_run++;
    if (addr_out_valid !== 1'b0 || addr_out !== '0
        || addr_out_last !== 1'b0 || cfg_err !== 1'b0
        || group_done !== '0 || group_busy !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: v=%b a=%h l=%b e=%b d=%b b=%b, want all 0",
               addr_out_valid, addr_out, addr_out_last, cfg_err,
               group_done, group_busy);
    end
    start = 1'b0;
    cfg_stride_v = 1'b0;
    addr_out_ready = 1'b0;
    reset = 1'b0;
    cyc();
    tests_run++;
    if (group_busy !== '0) begin
      tests_failed++;
      $display("FAIL reset_idle: busy=%b, want 0", group_busy);
    end
  endtask

  task automatic test_basic();
    do_reset();
    cfg_t1(0);
    go(0);
    push_walk(0, 48'h1000, 3, 2, 16'd4, 16'h100);
    drain(0, -1, -1, 0);
    chk_done(0, '0);
  endtask

  task automatic test_stall();
    do_reset();
    cfg_t1(0);
    go(0);
    push_walk(0, 48'h1000, 3, 2, 16'd4, 16'h100);
    drain(0, -1, 1, 3);
    chk_done(0, '0);
  endtask

  task automatic test_negative();
    do_reset();
    wr_iter(0, 0, 16'd4);
    wr_stride(0, 0, 16'hFFF8);
    wr_base(0, 48'h20);
    go(0);
    push_walk(0, 48'h20, 4, 0, 16'hFFF8, 16'h0);
    drain(0, -1, -1, 0);
    wr_iter(0, 0, 16'd2);
    wr_stride(0, 0, 16'hFFFC);
    wr_base(0, 48'h0);
    go(0);
    push_walk(0, 48'h0, 2, 0, 16'hFFFC, 16'h0);
    drain(0, -1, -1, 0);
    chk_done(0, '0);
  endtask

  task automatic test_groups();
    do_reset();
    cfg_t1(0);
    wr_iter(1, 0, 16'd4);
    wr_stride(1, 0, 16'h10);
    wr_base(1, 48'h8000);
    go(0);
    go(1);
    push_walk(0, 48'h1000, 3, 2, 16'd4, 16'h100);
    push_walk(1, 48'h8000, 4, 0, 16'h10, 16'h0);
    drain(0, 2, -1, 0);
    drain(1, 3, -1, 0);
    drain(0, -1, -1, 0);
    chk_done(0, 4'b0010);
    drain(1, -1, -1, 0);
    chk_done(1, '0);
  endtask

  task automatic test_cfg_err();
    do_reset();
    wr_iter(0, 0, 16'd4);
    wr_stride(0, 0, 16'd4);
    wr_base(0, 48'h100);
    go(0);
    push_walk(0, 48'h100, 4, 0, 16'd4, 16'h0);
    drain(0, 1, -1, 0);
    wr_stride(0, 0, 16'h40);
    tests_run++;
    if (cfg_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL cfg_err_active: got %b, want 1", cfg_err);
    end
    wr_base(1, 48'h5000);
    tests_run++;
    if (cfg_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL cfg_err_idle: got %b, want 0", cfg_err);
    end
    drain(0, 1, -1, 0);
    // restart while a handshake is offered: start wins
    addr_out_ready = 1'b1;
    go(0);
    addr_out_ready = 1'b0;
    drop_g(0);
    push_walk(0, 48'h100, 4, 0, 16'd4, 16'h0);
    drain(0, -1, -1, 0);
    chk_done(0, '0);
    cfg_group_id = '0;
    cfg_base = 48'h900;
    cfg_base_v = 1'b1;
    go(0);
    cfg_base_v = 1'b0;
    tests_run++;
    if (cfg_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL cfg_err_start: got %b, want 1", cfg_err);
    end
    push_walk(0, 48'h100, 4, 0, 16'd4, 16'h0);
    drain(0, -1, -1, 0);
    wr_iter(0, 0, 16'd0);
    go(0);
    push_walk(0, 48'h100, 0, 0, 16'd4, 16'h0);
    drain(0, -1, -1, 0);
    chk_done(0, '0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    cfg_t1(0);
    go(0);
    push_walk(0, 48'h1000, 3, 2, 16'd4, 16'h100);
    drain(0, 2, -1, 0);
    reset = 1'b1;
    addr_out_ready = 1'b1;
    cyc();
    addr_out_ready = 1'b0;
    reset = 1'b0;
    sbq.delete();
    tests_run++;
    if (addr_out_valid !== 1'b0 || group_busy !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid: valid=%b busy=%b, want 0 0",
               addr_out_valid, group_busy);
    end
    cfg_t1(0);
    go(0);
    push_walk(0, 48'h1000, 3, 2, 16'd4, 16'h100);
    drain(0, -1, -1, 0);
    chk_done(0, '0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    wr_iter(2, 0, 16'd2);
    wr_iter(2, 1, 16'd3);
    wr_stride(2, 0, 16'h8);
    wr_stride(2, 1, 16'hFF00);
    wr_base(2, 48'hFFFF_FFFF_FFF8);
    for (int r = 0; r < 2; r++) begin
      go(2);
      push_walk(2, 48'hFFFF_FFFF_FFF8, 2, 3, 16'h8, 16'hFF00);
      drain(2, -1, -1, 0);
      chk_done(2, '0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_negative();
    test_groups();
    test_cfg_err();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
